// File: rtl/quant_pkg.sv
// Shared constants and helpers for the 4x4 forward quantiser and zig-zag reorder.
// Holds the multiplier table, rounding offsets, scan order and control state encoding.
package quant_pkg;

    localparam logic [4:0] QBITS_BASE = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam logic [13:0] MF_A [6] = '{14'd13107, 14'd11916, 14'd10082, 14'd9362, 14'd8192, 14'd7282};
    localparam logic [13:0] MF_B [6] = '{14'd5243,  14'd4660,  14'd4194,  14'd3647, 14'd3355, 14'd2893};
    localparam logic [13:0] MF_C [6] = '{14'd8066,  14'd7490,  14'd6554,  14'd5825, 14'd5243, 14'd4559};

    localparam logic [3:0] ZIGZAG [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    function automatic logic [2:0] qp_div6(input logic [4:0] qp);
        if (qp < 5'd6) begin
            return 3'd0;
        end else if (qp < 5'd12) begin
            return 3'd1;
        end else if (qp < 5'd18) begin
            return 3'd2;
        end else if (qp < 5'd24) begin
            return 3'd3;
        end else if (qp < 5'd30) begin
            return 3'd4;
        end else begin
            return 3'd5;
        end
    endfunction

    function automatic logic [2:0] qp_mod6(input logic [4:0] qp, input logic [2:0] div);
        logic [4:0] six_div;
        six_div = ({2'b00, div} << 2) + ({2'b00, div} << 1);
        return 3'(qp - six_div);
    endfunction

    // Class A: even row and even column; class B: odd row and odd column.
    function automatic logic [13:0] mf_lookup(input logic [2:0] qp_mod, input logic [3:0] pos);
        if (qp_mod > 3'd5) begin
            return 14'd0;
        end else begin
            case (pos)
                4'd0, 4'd2, 4'd8, 4'd10:  return MF_A[qp_mod];
                4'd5, 4'd7, 4'd13, 4'd15: return MF_B[qp_mod];
                default:                  return MF_C[qp_mod];
            endcase
        end
    endfunction

    // floor(2^qbits/3) for intra, floor(2^qbits/6) for inter.
    function automatic logic [19:0] round_offset(input logic [2:0] div, input logic mode);
        case ({mode, div})
            4'b0_000: return 20'd10922;
            4'b0_001: return 20'd21845;
            4'b0_010: return 20'd43690;
            4'b0_011: return 20'd87381;
            4'b0_100: return 20'd174762;
            4'b0_101: return 20'd349525;
            4'b1_000: return 20'd5461;
            4'b1_001: return 20'd10922;
            4'b1_010: return 20'd21845;
            4'b1_011: return 20'd43690;
            4'b1_100: return 20'd87381;
            4'b1_101: return 20'd174762;
            default:  return 20'd0;
        endcase
    endfunction

endpackage

// File: rtl/quant_core.sv
// Combinational quantiser for one coefficient: sign/magnitude split, multiply,
// add rounding offset, shift by qbits, and restore the sign.
module quant_core
    import quant_pkg::*;
#(
    parameter int CW = 16,
    parameter int LW = 16
) (
    input  logic [CW-1:0] i_coeff,
    input  logic [4:0]    i_qp,
    input  logic          i_mode,
    input  logic [3:0]    i_pos,
    output logic [LW-1:0] o_level
);

    logic          w_neg;
    logic [CW-1:0] w_mag;
    logic [2:0]    w_div;
    logic [2:0]    w_mod;
    logic [13:0]   w_mf;
    logic [19:0]   w_off;
    logic [4:0]    w_qbits;
    logic [31:0]   w_sum;
    logic [LW-1:0] w_lvl;

    // The most negative input negates to 2^(CW-1), which is exact when read unsigned.
    assign w_neg   = i_coeff[CW-1];
    assign w_mag   = w_neg ? ((~i_coeff) + {{(CW-1){1'b0}}, 1'b1}) : i_coeff;
    assign w_div   = qp_div6(i_qp);
    assign w_mod   = qp_mod6(i_qp, w_div);
    assign w_mf    = mf_lookup(w_mod, i_pos);
    assign w_off   = round_offset(w_div, i_mode);
    assign w_qbits = QBITS_BASE + {2'b00, w_div};
    assign w_sum   = ({{(32-CW){1'b0}}, w_mag} * {18'd0, w_mf}) + {12'd0, w_off};
    assign w_lvl   = LW'(w_sum >> w_qbits);

    // Negating a zero magnitude yields zero, so no negative zero can appear.
    assign o_level = w_neg ? ((~w_lvl) + {{(LW-1){1'b0}}, 1'b1}) : w_lvl;

endmodule

// File: rtl/quant_zigzag_4x4.sv
// 4x4 block quantiser: accepts 16 raster coefficients, quantises through one pipeline
// register into a block buffer, then emits levels in zig-zag order. Option: QUANT_NZCOUNT_EN.
module quant_zigzag_4x4
    import quant_pkg::*;
#(
    parameter int CW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] coeff,
    input  logic [4:0]    qp,
    input  logic          mode,
    output logic          out_valid,
    output logic [LW-1:0] out_level,
    output logic          out_last
`ifdef QUANT_NZCOUNT_EN
    ,
    output logic [4:0]    out_nz
`endif
);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_in_ready;
    logic [3:0]    r_pos;
    logic [4:0]    r_qp;
    logic          r_mode;
    logic          w_accept;
    logic [4:0]    w_core_qp;
    logic          w_core_mode;
    logic [LW-1:0] w_core_level;
    logic          r_pipe_vld;
    logic [3:0]    r_pipe_addr;
    logic [LW-1:0] r_pipe_level;
    logic [LW-1:0] r_buf [16];
    logic [4:0]    r_emit_cnt;
    logic          r_out_valid;
    logic [LW-1:0] r_out_level;
    logic          r_out_last;

    assign w_accept  = in_valid && r_in_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_level = r_out_level;
    assign out_last  = r_out_last;

    // The first beat must be quantised with the live qp/mode, before they are latched.
    assign w_core_qp   = (r_state == ST_IDLE) ? qp : r_qp;
    assign w_core_mode = (r_state == ST_IDLE) ? mode : r_mode;

    quant_core #(
        .CW (CW),
        .LW (LW)
    ) u_core (
        .i_coeff (coeff),
        .i_qp    (w_core_qp),
        .i_mode  (w_core_mode),
        .i_pos   (r_pos),
        .o_level (w_core_level)
    );

    // Next-state decode for the block sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_accept && (r_pos == 4'd15)) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                w_state_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (r_emit_cnt == 5'd16) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_EMIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; ready is registered from the next state so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == ST_IDLE) || (w_state_next == ST_LOAD);
        end
    end

    // Input position counter and per-block qp/mode capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= 4'd0;
            r_qp   <= 5'd0;
            r_mode <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pos <= r_pos + 4'd1;
            end
            if (w_accept && (r_state == ST_IDLE)) begin
                r_qp   <= qp;
                r_mode <= mode;
            end
        end
    end

    // Pipeline register between the quantiser and the block buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld   <= 1'b0;
            r_pipe_addr  <= 4'd0;
            r_pipe_level <= {LW{1'b0}};
        end else begin
            r_pipe_vld <= w_accept;
            if (w_accept) begin
                r_pipe_addr  <= r_pos;
                r_pipe_level <= w_core_level;
            end
        end
    end

    // Block buffer, raster addressed; contents need no reset.
    always_ff @(posedge clk) begin
        if (r_pipe_vld) begin
            r_buf[r_pipe_addr] <= r_pipe_level;
        end
    end

    // Zig-zag readout; count value 16 is the trailing cycle that returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_emit_cnt  <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_level <= {LW{1'b0}};
            r_out_last  <= 1'b0;
        end else if ((r_state == ST_EMIT) && (r_emit_cnt != 5'd16)) begin
            r_emit_cnt  <= r_emit_cnt + 5'd1;
            r_out_valid <= 1'b1;
            r_out_level <= r_buf[ZIGZAG[r_emit_cnt[3:0]]];
            r_out_last  <= (r_emit_cnt == 5'd15);
        end else begin
            r_emit_cnt  <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_level <= {LW{1'b0}};
            r_out_last  <= 1'b0;
        end
    end

`ifdef QUANT_NZCOUNT_EN
    logic [4:0] r_nz;
    logic [4:0] r_out_nz;

    assign out_nz = r_out_nz;

    // Nonzero count follows buffer writes, so it is complete before readout begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nz     <= 5'd0;
            r_out_nz <= 5'd0;
        end else begin
            if (w_accept && (r_state == ST_IDLE)) begin
                r_nz <= 5'd0;
            end else if (r_pipe_vld && (r_pipe_level != {LW{1'b0}})) begin
                r_nz <= r_nz + 5'd1;
            end
            if ((r_state == ST_EMIT) && (r_emit_cnt == 5'd15)) begin
                r_out_nz <= r_nz;
            end else begin
                r_out_nz <= 5'd0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quant_zigzag_4x4.sv
// Self-checking bench for quant_zigzag_4x4 with an arithmetic reference model.
// Checks out_nz as well when QUANT_NZCOUNT_EN is defined.
module tb_quant_zigzag_4x4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] coeff;
    logic [4:0]  qp;
    logic        mode;
    logic        out_valid;
    logic [15:0] out_level;
    logic        out_last;
`ifdef QUANT_NZCOUNT_EN
    logic [4:0]  out_nz;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int t_last  = 0;
    int blk [16];

    int mf_tab [3][6] = '{
        '{13107, 11916, 10082, 9362, 8192, 7282},
        '{5243, 4660, 4194, 3647, 3355, 2893},
        '{8066, 7490, 6554, 5825, 5243, 4559}
    };
    int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    quant_zigzag_4x4 #(.CW(16), .LW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coeff     (coeff),
        .qp        (qp),
        .mode      (mode),
        .out_valid (out_valid),
        .out_level (out_level),
        .out_last  (out_last)
`ifdef QUANT_NZCOUNT_EN
        ,
        .out_nz    (out_nz)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_q(input int c, input int q, input bit m, input int p);
        int     row;
        int     col;
        int     cls;
        longint qb;
        longint f;
        longint a;
        longint r;
        row = p / 4;
        col = p % 4;
        if ((row % 2 == 0) && (col % 2 == 0))      cls = 0;
        else if ((row % 2 == 1) && (col % 2 == 1)) cls = 1;
        else                                       cls = 2;
        qb = 15 + q / 6;
        f  = (longint'(1) << qb) / (m ? 6 : 3);
        a  = (c < 0) ? -longint'(c) : longint'(c);
        r  = (a * mf_tab[cls][q % 6] + f) >> qb;
        return (c < 0) ? -int'(r) : int'(r);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = 0;
    endtask

    task automatic drive_block(input int q, input bit m, input int nbeats, input bit gaps);
        int p = 0;
        int budget = 0;
        while ((p < nbeats) && (budget < 400)) begin
            @(negedge clk);
            budget++;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                coeff    = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                coeff    = 16'(blk[p]);
                qp       = (p == 0) ? 5'(q) : 5'($urandom);
                mode     = (p == 0) ? m : 1'($urandom);
                if (in_ready) begin
                    p++;
                    if (p == 16) t_last = cyc + 1;
                end
            end
        end
        check("drive_beats", p, nbeats);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect_block(input int q, input bit m, input int rst_at);
        int exp [16];
        int nz = 0;
        int w = 0;
        int seen = 0;
        for (int k = 0; k < 16; k++) begin
            exp[k] = ref_q(blk[zz[k]], q, m, zz[k]);
            if (exp[k] != 0) nz++;
        end
        while (!out_valid && (w < 8)) begin
            check("busy_ready", int'(in_ready), 0);
            @(negedge clk);
            w++;
        end
        check("first_valid", int'(out_valid), 1);
        check("latency", cyc - t_last, 2);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("valid[%0d]", k), int'(out_valid), 1);
            check($sformatf("level[%0d]", k), int'($signed(out_level)), exp[k]);
            check($sformatf("last[%0d]", k), int'(out_last), (k == 15) ? 1 : 0);
            check($sformatf("emit_ready[%0d]", k), int'(in_ready), 0);
`ifdef QUANT_NZCOUNT_EN
            check($sformatf("nz[%0d]", k), int'(out_nz), (k == 15) ? nz : 0);
`endif
            if (k == rst_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_valid", int'(out_valid), 0);
                check("rst_level", int'(out_level), 0);
                check("rst_ready", int'(in_ready), 1);
                repeat (12) begin
                    @(negedge clk);
                    if (out_valid) seen++;
                end
                check("no_valid_after_rst", seen, 0);
                return;
            end
            in_valid = 1'($urandom);
            coeff    = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("post_valid", int'(out_valid), 0);
        check("post_level", int'(out_level), 0);
        check("post_last", int'(out_last), 0);
        check("post_ready", int'(in_ready), 1);
    endtask

    initial begin
        int q;
        bit m;
        int seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        coeff    = 16'd0;
        qp       = 5'd0;
        mode     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", int'(in_ready), 1);
        check("reset_valid", int'(out_valid), 0);
        check("reset_level", int'(out_level), 0);
        check("reset_last", int'(out_last), 0);
        rst = 1'b0;

        clear_blk();
        blk[0] = 100;
        drive_block(28, 1'b0, 16, 1'b0);
        collect_block(28, 1'b0, -1);

        clear_blk();
        blk[5] = -1000;
        drive_block(12, 1'b1, 16, 1'b0);
        collect_block(12, 1'b1, -1);

        clear_blk();
        blk[0] = 1;
        blk[3] = -1;
        drive_block(0, 1'b0, 16, 1'b0);
        collect_block(0, 1'b0, -1);

        for (int i = 0; i < 16; i++) blk[i] = 1000 * (i + 1);
        drive_block(6, 1'b0, 16, 1'b0);
        collect_block(6, 1'b0, -1);

        clear_blk();
        blk[0]  = 100;
        blk[1]  = -5000;
        blk[15] = 20000;
        drive_block(28, 1'b0, 16, 1'b0);
        collect_block(28, 1'b0, -1);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 65535)) - 32768;
            if (b == 0) begin
                blk[0] = -32768;
                blk[5] = 32767;
                blk[6] = -32768;
            end
            q = int'($urandom_range(0, 31));
            m = 1'($urandom);
            if (b == 1) q = 31;
            drive_block(q, m, 16, 1'b1);
            collect_block(q, m, -1);
        end

        for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 65535)) - 32768;
        drive_block(20, 1'b1, 16, 1'b1);
        collect_block(20, 1'b1, 7);

        for (int i = 0; i < 16; i++) blk[i] = 3000 + 17 * i;
        drive_block(9, 1'b0, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("load_rst_no_output", seen, 0);

        for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 65535)) - 32768;
        drive_block(17, 1'b0, 16, 1'b1);
        collect_block(17, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/quant_zigzag_4x4.md
Name: quant_zigzag_4x4

Overview:
- Forward H.264-style quantiser placed directly downstream of the Lab05 4x4 integer-transform stage.
- Receives 16 signed transform coefficients of one 4x4 block in raster order.
- Quantises each coefficient with a QP-dependent multiplier, rounding offset and shift.
- Buffers the whole block and re-emits the 16 levels in zig-zag scan order for the entropy-coding stage.

Parameters:
- CW, 16, coefficient input width (signed).
- LW, 16, output level width (signed).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  stage can accept a coefficient.
- coeff  in  CW  signed transform coefficient, raster order, position 0..15.
- qp  in  5  quantisation parameter 0..31; sampled with the first coefficient of a block.
- mode  in  1  0 = intra (offset 2^qbits/3), 1 = inter (offset 2^qbits/6); sampled with the first coefficient.
- out_valid  out  1  level valid.
- out_level  out  LW  signed quantised level, zig-zag order.
- out_last  out  1  high with the 16th level of a block.

Behaviour:
- Transfer rule: a coefficient is accepted when in_valid && in_ready at a rising clk edge. in_valid while in_ready=0 is ignored; no data is lost because upstream holds off.
- States:
  - IDLE: in_ready=1. First accept latches qp and mode, writes position 0, then goes to LOAD.
  - LOAD: in_ready=1. Accepts positions 1..15. The accept of position 15 goes to DRAIN.
  - DRAIN: in_ready=0. Waits one cycle for the quantiser pipeline register to retire the last level, then goes to EMIT.
  - EMIT: in_ready=0. 16 consecutive cycles of out_valid=1, then returns to IDLE.
  - Gaps between input beats are allowed (in_valid low) in both IDLE and LOAD.
- Latency: if the 16th coefficient is accepted at edge T, the first out_valid is seen after edge T+2. out_valid stays high for 16 consecutive cycles and out_last is high on the 16th. in_ready returns to 1 in the cycle after out_last.
- Quantisation, per coefficient c at raster position p (row = p[3:2], col = p[1:0]):
  - qbits = 15 + qp/6 (integer division).
  - f = floor(2^qbits / 3) for intra, floor(2^qbits / 6) for inter.
  - MF is selected by qp%6 and position class:
    - class A (row even and col even): 13107, 11916, 10082, 9362, 8192, 7282.
    - class B (row odd and col odd): 5243, 4660, 4194, 3647, 3355, 2893.
    - class C (all others): 8066, 7490, 6554, 5825, 5243, 4559.
  - level = sign(c) * ((|c| * MF + f) >> qbits). Magnitude arithmetic is unsigned, at least 32 bits wide.
  - |c| of -2^(CW-1) is handled without overflow.
  - A zero result has sign +, i.e. a negative c that quantises to 0 outputs 0.
- One register stage sits between the multiply/add/shift and the 16 x LW level buffer, which is written at raster address p.
- Zig-zag read order: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- Reset values: in_ready=1, out_valid=0, out_level=0, out_last=0, state=IDLE, position counter=0, emit counter=0. Buffer contents are don't-care.
- Output idle value: out_level and out_last are forced to 0 whenever out_valid=0.
- Reset mid-block (LOAD, DRAIN or EMIT): the partial or pending block is discarded and no further out_valid occurs. A new block starts at position 0.
- qp and mode changes after the first beat of a block are ignored until the next block.

Optional Feature:
- QUANT_NZCOUNT_EN defined:
  - Adds output port out_nz [4:0]: count of nonzero levels in the block (0..16).
  - out_nz is valid only while out_last=1 and is 0 otherwise.
  - The count is accumulated during LOAD/DRAIN and cleared at block start and on rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package quant_pkg holds:
  - the MF table constants (3 classes x 6 rows);
  - the zig-zag order constant array;
  - the state enum (IDLE, LOAD, DRAIN, EMIT);
  - localparams for qbits base 15.
- One sub-module, quant_core: combinational c, qp, mode, p -> level, instantiated once ahead of the pipeline register.

Test Plan:
- Single block, qp=28, intra, coeff[0]=100, others 0 -> outputs 1,0x15. out_last on output 16. First out_valid exactly 2 cycles after the 16th accept.
- qp=12, inter, coeff[5]=-1000, others 0 -> 5th output (zig-zag index 4) = -40, all other outputs 0.
- qp=0, intra, coeff[0]=1 -> all outputs 0, including the 0 result for -1 at position 3 (no negative zero).
- Raster input coeff[p] = 1000*(p+1), qp=6, intra -> output sequence matches the reference model in zig-zag order. in_ready=0 from the edge after accept 16 until the cycle after out_last. in_valid pulses during busy are ignored.
- Random gaps in in_valid, back-to-back blocks, and rst asserted on the 8th EMIT cycle -> out_valid drops the next cycle and the next block is quantised correctly from position 0.
- With QUANT_NZCOUNT_EN, block with 3 nonzero levels -> out_nz=3 on out_last and out_nz=0 elsewhere.
